snake_position_engine: RTL and testbench

SNAKE_POSITION_ENGINE -- requirements
Module: snake_position_engine

---
 rtl/snake_pkg.sv | 25 ++
 rtl/move_tick_gen.sv | 14 +
 rtl/snake_position_engine.sv | 66 ++++++
 tb/tb_snake_position_engine.sv | 137 +++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction encodings, grid defaults, cell type and wrap-around head step
package snake_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;
  function automatic cell_t step_cell(input cell_t c, input dir_t d, input int w, input int h);
    cell_t n;
    n.x = d == DIR_LEFT  ? (c.x == '0 ? X_W'(w - 1) : c.x - X_W'(1)) :
          d == DIR_RIGHT ? (c.x == X_W'(w - 1) ? '0 : c.x + X_W'(1)) : c.x;
    n.y = d == DIR_UP    ? (c.y == '0 ? Y_W'(h - 1) : c.y - Y_W'(1)) :
          d == DIR_DOWN  ? (c.y == Y_W'(h - 1) ? '0 : c.y + Y_W'(1)) : c.y;
    return n;
  endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: step strobe generator (CLK, RESET in; TICK high while the counter sits at TICK_DIV-1)
module move_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] tick_cnt;
  assign TICK = tick_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge CLK)
    tick_cnt <= RESET || TICK ? '0 : tick_cnt + CW'(1);
endmodule

// File: rtl/snake_position_engine.sv
// snake_position_engine: snake segment state (CLK/RESET, Navigation_State, TARGET_X/Y, QUERY_X/Y in; HEAD_X/Y, SNAKE_LEN, MOVE_TICK, TARGET_REACHED, sticky GAME_FAILED, registered ON_SNAKE out)
module snake_position_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Navigation_State,
  input  logic [7:0] TARGET_X,
  input  logic [6:0] TARGET_Y,
  input  logic [7:0] QUERY_X,
  input  logic [6:0] QUERY_Y,
  output logic [7:0] HEAD_X,
  output logic [6:0] HEAD_Y,
  output logic [4:0] SNAKE_LEN,
  output logic       MOVE_TICK,
  output logic       TARGET_REACHED,
  output logic       GAME_FAILED,
  output logic       ON_SNAKE
);
  cell_t seg [MAX_LEN];
  cell_t new_head;
  logic [MAX_LEN-1:0] hit_body, hit_query;
  logic step, collide, grab;
  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RESET(RESET),
    .TICK (MOVE_TICK)
  );
  assign new_head = step_cell(seg[0], dir_t'(Navigation_State), GRID_W, GRID_H);
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign hit_body[i]  = (i + 1 < int'(SNAKE_LEN)) && (seg[i] == new_head);
    assign hit_query[i] = (i < int'(SNAKE_LEN)) && (seg[i] == {QUERY_X, QUERY_Y});
  end
  assign step    = MOVE_TICK && !GAME_FAILED;
  assign collide = |hit_body;
  assign grab    = new_head == {TARGET_X, TARGET_Y};
  assign HEAD_X  = seg[0].x;
  assign HEAD_Y  = seg[0].y;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg[i].x <= X_W'(GRID_W / 2);
        seg[i].y <= Y_W'(GRID_H / 2 + i);
      end
      SNAKE_LEN      <= 5'(INIT_LEN);
      TARGET_REACHED <= 1'b0;
      GAME_FAILED    <= 1'b0;
      ON_SNAKE       <= 1'b0;
    end else begin
      ON_SNAKE       <= |hit_query;
      TARGET_REACHED <= step && !collide && grab;
      if (step && collide) GAME_FAILED <= 1'b1;
      if (step && !collide) begin
        seg[0] <= new_head;
        for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
        if (grab && SNAKE_LEN != 5'(MAX_LEN)) SNAKE_LEN <= SNAKE_LEN + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_snake_position_engine.sv
// tb_snake_position_engine: directed checks of ticking, wrap, capture, saturation, collision, query and reset priority
module tb_snake_position_engine;
  import snake_pkg::*;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] Navigation_State = DIR_UP;
  logic [7:0] TARGET_X = 8'd80;
  logic [6:0] TARGET_Y = 7'd59;
  logic [7:0] QUERY_X = 8'd80;
  logic [6:0] QUERY_Y = 7'd62;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic [4:0] SNAKE_LEN;
  logic       MOVE_TICK, TARGET_REACHED, GAME_FAILED, ON_SNAKE;
  int checks = 0;
  int errors = 0;
  snake_position_engine #(
    .GRID_W(160), .GRID_H(120), .MAX_LEN(5), .INIT_LEN(4), .TICK_DIV(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Navigation_State(Navigation_State),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .QUERY_X(QUERY_X), .QUERY_Y(QUERY_Y),
    .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .SNAKE_LEN(SNAKE_LEN), .MOVE_TICK(MOVE_TICK),
    .TARGET_REACHED(TARGET_REACHED), .GAME_FAILED(GAME_FAILED), .ON_SNAKE(ON_SNAKE)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int j = 0; j < 8 && !seen; j++) begin
      @(negedge CLK);
      seen = MOVE_TICK;
    end
    chk("tick_seen", 32'(seen), 1);
  endtask
  task automatic run_ticks(input logic [1:0] d, input int n);
    Navigation_State = d;
    for (int k = 0; k < n; k++) wait_tick();
    @(negedge CLK);
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_head_x", HEAD_X, 80);
    chk("rst_head_y", HEAD_Y, 60);
    chk("rst_len", SNAKE_LEN, 4);
    chk("rst_failed", GAME_FAILED, 0);
    chk("rst_treached", TARGET_REACHED, 0);
    chk("rst_on_snake", ON_SNAKE, 0);
    RESET = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge CLK);
      chk($sformatf("move_tick_c%0d", c), MOVE_TICK, 32'(c % 4 == 0));
      if (c == 2) begin
        chk("on_snake_80_62", ON_SNAKE, 1);
        QUERY_Y = 7'd64;
      end
      if (c == 3) chk("on_snake_80_64", ON_SNAKE, 0);
      if (c == 4) begin
        chk("treached_before", TARGET_REACHED, 0);
        chk("len_before", SNAKE_LEN, 4);
      end
      if (c == 5) begin
        chk("treached_first", TARGET_REACHED, 1);
        chk("len_grow", SNAKE_LEN, 5);
        chk("head_x_t1", HEAD_X, 80);
        chk("head_y_t1", HEAD_Y, 59);
        TARGET_Y = 7'd58;
      end
      if (c == 6) chk("treached_one_cycle", TARGET_REACHED, 0);
      if (c == 9) begin
        chk("treached_second", TARGET_REACHED, 1);
        chk("len_saturate", SNAKE_LEN, 5);
        chk("head_y_t2", HEAD_Y, 58);
        TARGET_X = 8'd200;
        TARGET_Y = 7'd0;
      end
      if (c == 13) begin
        chk("head_x_t3", HEAD_X, 80);
        chk("head_y_t3", HEAD_Y, 57);
      end
    end
    run_ticks(DIR_LEFT, 1);
    chk("loop_left_x", HEAD_X, 79);
    chk("loop_left_y", HEAD_Y, 57);
    run_ticks(DIR_DOWN, 1);
    chk("loop_down_y", HEAD_Y, 58);
    chk("loop_failed_pre", GAME_FAILED, 0);
    run_ticks(DIR_RIGHT, 1);
    chk("collide_failed", GAME_FAILED, 1);
    chk("collide_head_x", HEAD_X, 79);
    chk("collide_treached", TARGET_REACHED, 0);
    run_ticks(DIR_RIGHT, 3);
    chk("frozen_head_x", HEAD_X, 79);
    chk("frozen_head_y", HEAD_Y, 58);
    chk("frozen_len", SNAKE_LEN, 5);
    chk("frozen_failed", GAME_FAILED, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst2_failed", GAME_FAILED, 0);
    chk("rst2_head_y", HEAD_Y, 60);
    chk("rst2_len", SNAKE_LEN, 4);
    RESET = 1'b0;
    run_ticks(DIR_RIGHT, 79);
    chk("edge_x_159", HEAD_X, 159);
    run_ticks(DIR_RIGHT, 1);
    chk("wrap_x_0", HEAD_X, 0);
    chk("wrap_x_y_kept", HEAD_Y, 60);
    run_ticks(DIR_UP, 60);
    chk("edge_y_0", HEAD_Y, 0);
    run_ticks(DIR_UP, 1);
    chk("wrap_y_119", HEAD_Y, 119);
    chk("wrap_y_x_kept", HEAD_X, 0);
    run_ticks(DIR_RIGHT, 10);
    run_ticks(DIR_UP, 109);
    wait_tick();
    chk("pre_rst_head_x", HEAD_X, 10);
    chk("pre_rst_head_y", HEAD_Y, 10);
    RESET = 1'b1;
    TARGET_X = 8'd10;
    TARGET_Y = 7'd9;
    @(negedge CLK);
    chk("rst_tick_head_x", HEAD_X, 80);
    chk("rst_tick_head_y", HEAD_Y, 60);
    chk("rst_tick_len", SNAKE_LEN, 4);
    chk("rst_tick_failed", GAME_FAILED, 0);
    chk("rst_tick_treached", TARGET_REACHED, 0);
    chk("rst_tick_move", MOVE_TICK, 0);
    RESET = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
